// File: rtl/bcd2bin_seq.sv
// Multi-cycle packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 on err.
module bcd2bin_seq #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]       bin,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [0:0]             r_state;
  logic [4*NDIGITS-1:0]   r_shift;
  logic [BIN_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovfInt;
  logic [BIN_W-1:0]       r_bin;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;

  logic [3:0]             w_digit;
  logic [BIN_W+3:0]       w_mul;
  logic [BIN_W-1:0]       w_accNext;
  logic                   w_stepOvf;
  logic                   w_last;

  // acc*10 + d done as two shifts and adds; four guard bits catch the carry-out
  assign w_digit   = r_shift[4*NDIGITS-1 -: 4];
  assign w_mul     = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                   + {{BIN_W{1'b0}}, w_digit};
  assign w_accNext = w_mul[BIN_W-1:0];
  assign w_stepOvf = |w_mul[BIN_W+3:BIN_W];
  assign w_last    = (r_cnt == CNT_W'(NDIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovfInt <= 1'b0;
      r_bin    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift  <= bcd;
            r_acc    <= '0;
            r_ovfInt <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc    <= w_accNext;
          r_ovfInt <= r_ovfInt | w_stepOvf;
          r_shift  <= r_shift << 4;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bin   <= w_accNext;
            r_ovf   <= r_ovfInt | w_stepOvf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_errInt;
  logic r_err;
  logic w_digitBad;

  // The check only flags; arithmetic above still uses the raw nibble
  assign w_digitBad = (w_digit > 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_errInt <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) r_errInt <= 1'b0;
    end else begin
      r_errInt <= r_errInt | w_digitBad;
      if (w_last) r_err <= r_errInt | w_digitBad;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign bin  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: a 10-bit and a 9-bit instance share stimulus
// and are compared every cycle against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

  localparam int ND = 3;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [11:0]   bcd;
  logic [9:0]    bin10;
  logic          busy10, done10, ovf10, err10;
  logic [8:0]    bin9;
  logic          busy9, done9, ovf9, err9;

  int assertCount = 0;
  int failCount   = 0;

  bcd2bin_seq #(.NDIGITS(ND), .BIN_W(10)) dut10 (
    .clk(clk), .reset(reset), .start(start), .bcd(bcd),
    .bin(bin10), .busy(busy10), .done(done10), .ovf(ovf10), .err(err10)
  );

  bcd2bin_seq #(.NDIGITS(ND), .BIN_W(9)) dut9 (
    .clk(clk), .reset(reset), .start(start), .bcd(bcd),
    .bin(bin9), .busy(busy9), .done(done9), .ovf(ovf9), .err(err9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one value and records the outcome
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Decimal value of a packed BCD word, raw nibbles weighted by powers of ten
  function automatic longint decimalValue(input logic [11:0] v);
    longint sum = 0;
    longint weight = 1;
    for (int k = 0; k < ND; k++) begin
      sum += longint'(v[4*k +: 4]) * weight;
      weight *= 10;
    end
    return sum;
  endfunction

  function automatic bit anyBadDigit(input logic [11:0] v);
    bit bad = 1'b0;
    for (int k = 0; k < ND; k++) if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Reference model: a conversion accepted while idle finishes ND edges later
  bit     seenEdge = 1'b0;
  bit     mBusy = 1'b0;
  bit     mDone = 1'b0;
  int     mLeft = 0;
  longint mValue = 0;
  bit     mBad = 1'b0;
  int     mBin[2] = '{0, 0};
  bit     mOvf[2] = '{1'b0, 1'b0};
  bit     mErr = 1'b0;
  int     widths[2] = '{10, 9};

  always @(posedge clk) begin
    seenEdge = 1'b1;
    if (reset) begin
      mBusy = 1'b0;
      mDone = 1'b0;
      mLeft = 0;
      mErr  = 1'b0;
      for (int u = 0; u < 2; u++) begin
        mBin[u] = 0;
        mOvf[u] = 1'b0;
      end
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mErr  = ERR_EN && mBad;
          for (int u = 0; u < 2; u++) begin
            mBin[u] = int'(mValue % (64'd1 << widths[u]));
            mOvf[u] = (mValue >= (64'd1 << widths[u]));
          end
        end
      end else if (start) begin
        mBusy  = 1'b1;
        mLeft  = ND;
        mValue = decimalValue(bcd);
        mBad   = anyBadDigit(bcd);
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (seenEdge) begin
      checkOutput("busy10", busy10, mBusy);
      checkOutput("done10", done10, mDone);
      checkOutput("bin10",  bin10,  mBin[0]);
      checkOutput("ovf10",  ovf10,  mOvf[0]);
      checkOutput("err10",  err10,  mErr);
      checkOutput("busy9",  busy9,  mBusy);
      checkOutput("done9",  done9,  mDone);
      checkOutput("bin9",   bin9,   mBin[1]);
      checkOutput("ovf9",   ovf9,   mOvf[1]);
      checkOutput("err9",   err9,   mErr);
    end
  end

  // Drives inputs for one cycle; called on a falling edge
  task automatic applyStimulus(input logic s, input logic [11:0] b);
    start = s;
    bcd   = b;
    @(negedge clk);
  endtask

  task automatic waitDone(output int cyclesWaited);
    cyclesWaited = 0;
    while (!done10 && cyclesWaited < 20) begin
      @(negedge clk);
      cyclesWaited++;
    end
    if (!done10) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic countDones(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done10) pulses++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    bcd   = 12'h000;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstBin",  bin10,  32'd0);
    checkOutput("rstBusy", busy10, 32'd0);
    checkOutput("rstDone", done10, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single conversion of 131
    applyStimulus(1'b1, 12'h131);
    applyStimulus(1'b0, 12'h131);
    waitDone(waited);
    checkOutput("lat131",   waited, 32'd2);
    checkOutput("lit131",   bin10,  32'd131);
    checkOutput("lit131w9", bin9,   32'd131);
    checkOutput("ovf131",   ovf10,  32'd0);
    checkOutput("err131",   err10,  32'd0);
    applyStimulus(1'b0, 12'h000);

    // Back-to-back with start held: 999 then 000
    applyStimulus(1'b1, 12'h999);
    start = 1'b1;
    bcd   = 12'h000;
    waitDone(waited);
    checkOutput("lit999",    bin10, 32'd999);
    checkOutput("ovf999w10", ovf10, 32'd0);
    checkOutput("lit999w9",  bin9,  32'd487);
    checkOutput("ovf999w9",  ovf9,  32'd1);
    applyStimulus(1'b1, 12'h000);
    start = 1'b0;
    waitDone(waited);
    checkOutput("b2bGap",   waited + 1, 32'd4);
    checkOutput("lit000",   bin10, 32'd0);
    checkOutput("ovf000w9", ovf9,  32'd0);
    applyStimulus(1'b0, 12'h000);

    // 9-bit instance recovers from overflow on the next conversion
    applyStimulus(1'b1, 12'h100);
    applyStimulus(1'b0, 12'h100);
    waitDone(waited);
    checkOutput("lit100w9", bin9, 32'd100);
    checkOutput("ovf100w9", ovf9, 32'd0);
    applyStimulus(1'b0, 12'h000);

    // start pulse and bcd change mid-conversion are ignored
    applyStimulus(1'b1, 12'h131);
    applyStimulus(1'b1, 12'h555);
    applyStimulus(1'b0, 12'h777);
    waitDone(waited);
    checkOutput("ignLit", bin10, 32'd131);
    countDones(6, pulses);
    checkOutput("ignPulses", pulses, 32'd0);

    // Reset two cycles into a conversion aborts it
    applyStimulus(1'b1, 12'h456);
    applyStimulus(1'b0, 12'h456);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortBin",  bin10,  32'd0);
    checkOutput("abortBusy", busy10, 32'd0);
    checkOutput("abortDone", done10, 32'd0);
    reset = 1'b0;
    countDones(6, pulses);
    checkOutput("abortPulses", pulses, 32'd0);
    applyStimulus(1'b1, 12'h042);
    applyStimulus(1'b0, 12'h042);
    waitDone(waited);
    checkOutput("lit042", bin10, 32'd42);
    applyStimulus(1'b0, 12'h000);

    // Non-decimal nibble: raw value used, err only when the check is built
    applyStimulus(1'b1, 12'h1A3);
    applyStimulus(1'b0, 12'h1A3);
    waitDone(waited);
    checkOutput("lit1A3",   bin10, 32'd203);
    checkOutput("lit1A3w9", bin9,  32'd203);
    checkOutput("err1A3",   err10, ERR_EN ? 32'd1 : 32'd0);
    applyStimulus(1'b0, 12'h000);
    applyStimulus(1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Parametrised multi-cycle BCD-to-binary converter. Successor to the fixed 3-digit bcd2bin: the digit count and output width are generic, it adds a busy/done handshake and an overflow flag, and an optional invalid-digit check. It converts one digit per clock, most significant first, using acc = acc*10 + digit. It sits between keypad/BCD entry logic and binary datapath consumers.

Parameters:
NDIGITS, 3, number of packed BCD digits (1..8)
BIN_W, 10, output width in bits; must be >=1; values below ceil(log2(10^NDIGITS)) are legal but can overflow

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only when busy=0
bcd  input  4*NDIGITS  packed digits; bcd[4*NDIGITS-1 -: 4] is the most significant digit; captured on the accepted start edge
bin  output  BIN_W  binary result; held until the next completion
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bin/ovf/err update
ovf  output  1  result exceeded 2^BIN_W-1; valid with done, held with bin
err  output  1  invalid digit seen (see Optional Feature); valid with done, held with bin

Behaviour:
- Reset: on any clock edge with reset=1, state=IDLE, bin=0, busy=0, done=0, ovf=0, err=0, internal accumulator and digit counter=0. Reset has priority over all other inputs, including during CONV; an aborted conversion produces no done.
- FSM has two states, IDLE and CONV.
- IDLE:
  - start=1 at an edge: capture bcd into the shift register, clear acc, ovf_int and err_int, set cnt=0, go to CONV, busy=1.
  - start=0: stay in IDLE.
- CONV, at each edge:
  - Take the top 4-bit digit d and compute acc_next = acc*10 + d, with *10 implemented as (acc<<3)+(acc<<1).
  - acc is BIN_W bits; any carry/bits above BIN_W-1 in acc_next set the sticky ovf_int; acc keeps the low BIN_W bits (result is modulo 2^BIN_W).
  - Shift the register left by 4; cnt++.
  - On the edge where cnt==NDIGITS-1: load bin=acc_next (truncated), ovf=ovf_int (including this step), err=err_int (including this step), done=1, busy=0, and return to IDLE.
- Latency: start accepted at edge E gives done=1 in the cycle after edge E+NDIGITS. For NDIGITS=3, that is 3 cycles after the start edge.
- done is high for exactly one cycle. bin, ovf and err are stable from that cycle until the next completion or reset.
- start while busy=1 is ignored and never queued. bcd changes during CONV have no effect.
- Back-to-back: the done cycle is IDLE, so start=1 in that cycle is accepted at the next edge. Holding start high therefore runs continuous conversions, one every NDIGITS+1 cycles.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
Macro: BCD2BIN_DIGIT_CHECK_EN
- Defined: any processed digit >9 sets the sticky err_int, reported on err with done. The arithmetic still uses the raw 4-bit value, so bin is computed normally.
- Not defined: no check logic is built, err is tied to 0, and digits 10..15 are used as raw values.

Test Plan:
- NDIGITS=3, BIN_W=10; after reset, bcd=0x131, start for 1 cycle -> busy for 3 cycles, then done pulse with bin=131 (0x083), ovf=0, err=0.
- bcd=0x999 then bcd=0x000, back-to-back with start held high -> bin=999 then bin=0, done pulses 4 cycles apart, bin stable between pulses.
- BIN_W=9, bcd=0x999 -> bin=487 (999 mod 512), ovf=1; next conversion of bcd=0x100 -> bin=100, ovf=0.
- start pulsed again and bcd changed mid-CONV during a 0x131 conversion -> ignored; result 131 at the original done time, only one done pulse.
- reset asserted 2 cycles into a conversion -> next cycle bin=0, busy=0, done=0; no done pulse follows; a new start gives a correct result.
- With BCD2BIN_DIGIT_CHECK_EN, bcd=0x1A3 -> done with err=1, bin=203 (1*100+10*10+3). Without the macro, same stimulus -> err=0, bin=203.
